// File: rtl/key_expansion_pkg.sv
// Shared AES definitions: round count, key-schedule FSM encoding,
// round constants and the S-box used by SubWord and SubBytes.
package key_expansion_pkg;

    // AES-128 only: ten rounds, eleven round keys (indices 0..10).
    localparam int AES_NR = 10;

    // Key-schedule controller states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ke_state_t;

    // Round constants. Entry i is used when deriving round key i+1 from key i.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // AES forward S-box, indexed by input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Single S-box lookup.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant byte for deriving key idx+1 from key idx; zero past the table.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if (idx < 4'd10) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/key_expansion_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, same table as SubBytes.
module key_subword
    import key_expansion_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Byte-wise substitution; byte order is preserved.
    always_comb begin
        word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                    sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule. Streams round keys 0..10 over a valid/ready
// handshake, deriving each next key from the registered one in one cycle.
module key_expansion
    import key_expansion_pkg::*;
#(
    // Only AES-128 (10 rounds) is supported.
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done
);

    localparam logic [3:0] LAST_INDEX = 4'(NR);

    ke_state_t    state;
    ke_state_t    next_state;
    logic         start_accept;
    logic         beat_accept;
    logic         last_beat;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    // State register; synchronous reset dominates everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values;
        // a blocking = here would let later reads in the same edge see new values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        next_state = state;
        ready      = 1'b0;
        rk_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                rk_valid = 1'b1;
                if (rk_ready && (rk_index == LAST_INDEX)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake qualifiers shared by the datapath register.
    always_comb begin
        start_accept = ready && start;
        beat_accept  = rk_valid && rk_ready;
        last_beat    = beat_accept && (rk_index == LAST_INDEX);
    end

    // Word split and RotWord of the last word of the current key.
    always_comb begin
        {w0, w1, w2, w3} = round_key;
        rot_w3           = {w3[23:0], w3[31:24]};
    end

    key_subword u_subword (
        .word_in  (rot_w3),
        .word_out (sub_w3)
    );

    // Next round key: chained XOR of the words after mixing in t.
    always_comb begin
        t_word   = sub_w3 ^ {rcon(rk_index), 24'h000000};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Key register, round counter and done pulse. The key is held in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_key <= '0;
            rk_index  <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_beat;
            if (start_accept) begin
                round_key <= key_in;
                rk_index  <= '0;
            end else if (beat_accept) begin
                if (last_beat) begin
                    rk_index <= '0;
                end else begin
                    round_key <= next_key;
                    rk_index  <= rk_index + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 vectors through a scoreboard
// queue, plus backpressure, ignored start, mid-run reset and start-on-done.
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;

    always #5 clk = ~clk;

    key_expansion #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .ready     (ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_index  (rk_index),
        .round_key (round_key),
        .done      (done)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         check_key;
    } beat_t;

    localparam logic [127:0] KEY_A1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_C1_LAST = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    beat_t  fips_a1 [11];
    beat_t  sb_q [$];
    int     checks = 0;
    int     errors = 0;
    logic   expect_done = 1'b0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Queue the beats a freshly accepted key should produce.
    task automatic push_expect(input logic [127:0] key);
        beat_t b;
        if (key == KEY_A1) begin
            foreach (fips_a1[i]) sb_q.push_back(fips_a1[i]);
        end else begin
            for (int i = 0; i <= 10; i++) begin
                b.idx       = 4'(i);
                b.check_key = (i == 0) || (i == 10);
                b.key       = (i == 0) ? key : ((i == 10) ? KEY_C1_LAST : '0);
                sb_q.push_back(b);
            end
        end
    endtask

    // Compare current outputs with the scoreboard; inputs for the coming edge are already driven.
    task automatic observe();
        logic idle;
        idle = (sb_q.size() == 0);
        check("done", 128'(done), 128'(expect_done));
        expect_done = 1'b0;
        check("ready", 128'(ready), 128'(idle));
        check("rk_valid", 128'(rk_valid), 128'(!idle));
        if (!rk_valid) begin
            check("rk_index_idle", 128'(rk_index), 128'(0));
        end
        if (rk_valid && !idle) begin
            check($sformatf("rk_index[%0d]", sb_q[0].idx), 128'(rk_index), 128'(sb_q[0].idx));
            if (sb_q[0].check_key) begin
                check($sformatf("round_key[%0d]", sb_q[0].idx), round_key, sb_q[0].key);
            end
            if (rk_ready && !rst) begin
                if (sb_q[0].idx == 4'd10) expect_done = 1'b1;
                void'(sb_q.pop_front());
            end
        end
        if (start && !rst && idle) begin
            push_expect(key_in);
        end
    endtask

    // Drive one cycle of inputs, check outputs, then advance one clock.
    task automatic cycle(input logic s, input logic [127:0] k, input logic r, input logic rs = 1'b0);
        start    = s;
        key_in   = k;
        rk_ready = r;
        rst      = rs;
        observe();
        @(posedge clk);
        #1;
        if (rs) begin
            sb_q.delete();
            expect_done = 1'b0;
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Run with rk_ready high until every queued beat is consumed.
    task automatic drain(input string name);
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) begin
            cycle(1'b0, rand_key(), 1'b1);
        end
        check({"drain_", name}, 128'(sb_q.size()), 128'(0));
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a1_keys [11];
        int           valid_cnt;

        a1_keys = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f,
            128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00,
            128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd,
            128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f,
            128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6
        };
        foreach (a1_keys[i]) fips_a1[i] = '{4'(i), a1_keys[i], 1'b1};

        // Reset state.
        rst = 1'b1; start = 1'b1; key_in = KEY_A1; rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_done", 128'(done), 128'(0));
        check("rst_rk_index", 128'(rk_index), 128'(0));
        check("rst_round_key", round_key, 128'(0));
        cycle(1'b0, '0, 1'b1);

        // FIPS-197 A.1 with rk_ready high; key_in scrambled after acceptance.
        cycle(1'b1, KEY_A1, 1'b1);
        drain("a1");
        cycle(1'b0, rand_key(), 1'b1);
        check("idle_hold_key", round_key, a1_keys[10]);

        // FIPS-197 C.1: eleven consecutive valid cycles.
        cycle(1'b1, KEY_C1, 1'b1);
        valid_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            if (rk_valid) valid_cnt++;
            cycle(1'b0, rand_key(), 1'b1);
        end
        check("c1_back_to_back", 128'(valid_cnt), 128'(11));
        drain("c1");
        cycle(1'b0, rand_key(), 1'b1);

        // Backpressure: key 4 held for three stalled cycles plus the accepting one.
        cycle(1'b1, KEY_A1, 1'b1);
        repeat (4) cycle(1'b0, rand_key(), 1'b1);
        repeat (3) cycle(1'b0, rand_key(), 1'b0);
        drain("backpressure");
        cycle(1'b0, rand_key(), 1'b1);

        // Start with a different key while key 5 is shown: ignored.
        cycle(1'b1, KEY_A1, 1'b1);
        repeat (5) cycle(1'b0, rand_key(), 1'b1);
        cycle(1'b1, KEY_C1, 1'b1);
        drain("start_ignored");
        cycle(1'b0, rand_key(), 1'b1);

        // Reset while key 6 is shown: abort with no done pulse.
        cycle(1'b1, KEY_A1, 1'b1);
        repeat (6) cycle(1'b0, rand_key(), 1'b1);
        cycle(1'b1, KEY_C1, 1'b1, 1'b1);
        check("abort_rk_valid", 128'(rk_valid), 128'(0));
        check("abort_round_key", round_key, 128'(0));
        check("abort_ready", 128'(ready), 128'(1));
        check("abort_done", 128'(done), 128'(0));
        repeat (2) cycle(1'b0, rand_key(), 1'b1);
        cycle(1'b1, KEY_A1, 1'b1);
        drain("after_abort");

        // Start in the done cycle: C.1 key 0 on the following cycle.
        cycle(1'b1, KEY_C1, 1'b1);
        drain("start_on_done");
        cycle(1'b0, rand_key(), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
